// File: rtl/seg2bin_rx.sv
// seg2bin_rx: converts a two-digit active-low seven-segment display reading
// plus a sign flag into a signed two's-complement byte. Segment patterns are
// decoded to BCD, then converted to binary by reverse double-dabble.
//
// Handshake: start is a request sampled only while idle; an accepted start
// raises busy on the same edge and busy stays high until the result is
// ready. done is a single-cycle pulse during which value, mag_bcd and err
// are valid. Those three outputs then hold until the next accepted start.
// Any start seen while busy or during done is dropped, never queued.

module seg2bin_rx (
    input  logic       clk,
    input  logic       ar,
    input  logic       start,
    input  logic [6:0] tens_seg,
    input  logic [6:0] ones_seg,
    input  logic       neg_in,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] value,
    output logic [7:0] mag_bcd
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_SHIFT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  tens_q, tens_d;
    logic [6:0]  ones_q, ones_d;
    logic        neg_q, neg_d;
    logic [14:0] sr_q, sr_d;      // {bcd tens, bcd ones, binary}
    logic [2:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [7:0]  value_q, value_d;
    logic [7:0]  mag_q, mag_d;

    logic [4:0]  tens_dec;        // {valid, digit}
    logic [4:0]  ones_dec;
    logic [14:0] sr_shift;
    logic [14:0] sr_step;
    logic [7:0]  mag_bin;

    // Returns {valid, digit}. A blank pattern is a leading zero, so it is only
    // accepted where blank_ok is set (the tens digit).
    function automatic logic [4:0] dec_seg(input logic [6:0] seg, input logic blank_ok);
        logic [4:0] r;
        case (seg)
            7'h40:   r = {1'b1, 4'd0};
            7'h79:   r = {1'b1, 4'd1};
            7'h24:   r = {1'b1, 4'd2};
            7'h30:   r = {1'b1, 4'd3};
            7'h19:   r = {1'b1, 4'd4};
            7'h12:   r = {1'b1, 4'd5};
            7'h02:   r = {1'b1, 4'd6};
            7'h78:   r = {1'b1, 4'd7};
            7'h00:   r = {1'b1, 4'd8};
            7'h10:   r = {1'b1, 4'd9};
            7'h7F:   r = blank_ok ? {1'b1, 4'd0} : 5'd0;
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    // One reverse double-dabble iteration: shift right, then pull each BCD
    // nibble that reached 8 or more back down by 3.
    always_comb begin
        sr_shift = {1'b0, sr_q[14:1]};
        sr_step  = sr_shift;
        if (sr_shift[14:11] >= 4'd8) begin
            sr_step[14:11] = sr_shift[14:11] - 4'd3;
        end
        if (sr_shift[10:7] >= 4'd8) begin
            sr_step[10:7] = sr_shift[10:7] - 4'd3;
        end
        mag_bin = {1'b0, sr_step[6:0]};
    end

    // Segment decode of the captured patterns, used in DECODE and at the end of SHIFT.
    always_comb begin
        tens_dec = dec_seg(tens_q, 1'b1);
        ones_dec = dec_seg(ones_q, 1'b0);
    end

    // Next-state and datapath update for the conversion sequence.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        neg_d   = neg_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        value_d = value_q;
        mag_d   = mag_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tens_d  = tens_seg;
                    ones_d  = ones_seg;
                    neg_d   = neg_in;
                    err_d   = 1'b0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (tens_dec[4] && ones_dec[4]) begin
                    sr_d    = {tens_dec[3:0], ones_dec[3:0], 7'd0};
                    cnt_d   = 3'd0;
                    state_d = S_SHIFT;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_SHIFT: begin
                sr_d = sr_step;
                if (cnt_q == 3'd6) begin
                    // A zero magnitude stays 8'h00 whatever the sign.
                    if (neg_q && (mag_bin != 8'd0)) begin
                        value_d = (~mag_bin) + 8'd1;
                    end else begin
                        value_d = mag_bin;
                    end
                    mag_d   = {tens_dec[3:0], ones_dec[3:0]};
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (ar) begin
            state_q <= S_IDLE;
            tens_q  <= 7'd0;
            ones_q  <= 7'd0;
            neg_q   <= 1'b0;
            sr_q    <= 15'd0;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
            value_q <= 8'd0;
            mag_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            neg_q   <= neg_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            value_q <= value_d;
            mag_q   <= mag_d;
        end
    end

    // Status flags come straight from the state so they follow it exactly.
    always_comb begin
        busy    = (state_q == S_DECODE) || (state_q == S_SHIFT);
        done    = (state_q == S_DONE);
        err     = err_q;
        value   = value_q;
        mag_bcd = mag_q;
    end

endmodule
